// File: rtl/mem_io_responder.sv
// Memory-side responder for the 6-bit-address / 8-bit-data CPU bus.
// Holds the program RAM, two memory-mapped I/O registers and the byte-stream loader that gates the CPU reset.
module mem_io_responder #(
    parameter int AW          = 6,
    parameter int DW          = 8,
    parameter int IO_IN_ADDR  = 62,
    parameter int IO_OUT_ADDR = 63
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_clr_n,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic          ld_last,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic [DW-1:0] io_in,
    output logic [DW-1:0] io_out,
    output logic          io_strobe,
    output logic [1:0]    state_o
);

    localparam int            RAM_WORDS = 2**AW - 2;
    localparam logic [AW-1:0] A_IN      = AW'(IO_IN_ADDR);
    localparam logic [AW-1:0] A_OUT     = AW'(IO_OUT_ADDR);
    localparam logic [AW-1:0] LAST_PTR  = AW'(RAM_WORDS - 1);

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_ptr_nx;
    logic          w_ld_we;
    logic          w_cpu_ram_we;
    logic          w_cpu_out_we;
    logic [DW-1:0] r_mem [RAM_WORDS];
    logic [DW-1:0] r_io_out;
    logic          r_io_strobe;
    logic [DW-1:0] r_sync1;
    logic [DW-1:0] r_sync2;
    logic [DW-1:0] w_rdata;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= HOLD;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
        end
    end

    // A restart pulse in LOAD takes priority over a byte offered in the same cycle.
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_ld_we    = 1'b0;
        case (r_state)
            HOLD, RUN: begin
                if (ld_start) begin
                    w_state_nx = LOAD;
                    w_ptr_nx   = '0;
                end
            end
            LOAD: begin
                if (ld_start) begin
                    w_ptr_nx = '0;
                end else if (ld_valid) begin
                    w_ld_we  = ~clr;
                    w_ptr_nx = r_ptr + AW'(1);
                    if (ld_last || (r_ptr == LAST_PTR)) begin
                        w_state_nx = RUN;
                    end
                end
            end
            default: w_state_nx = HOLD;
        endcase
    end

    assign w_cpu_ram_we = ~clr && (r_state == RUN) && cpu_we && (cpu_addr < A_IN);
    assign w_cpu_out_we = ~clr && (r_state == RUN) && cpu_we && (cpu_addr == A_OUT);

    always_ff @(posedge clk) begin
        if (w_ld_we) begin
            r_mem[r_ptr] <= ld_data;
        end else if (w_cpu_ram_we) begin
            r_mem[cpu_addr] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_io_out    <= '0;
            r_io_strobe <= 1'b0;
            r_sync1     <= '0;
            r_sync2     <= '0;
        end else begin
            r_io_strobe <= w_cpu_out_we;
            if (w_cpu_out_we) begin
                r_io_out <= cpu_wdata;
            end
            r_sync1 <= io_in;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (r_state == RUN) begin
            if (cpu_addr == A_OUT) begin
                w_rdata = r_io_out;
            end else if (cpu_addr == A_IN) begin
                w_rdata = r_sync2;
            end else begin
                w_rdata = r_mem[cpu_addr];
            end
        end
    end

    assign cpu_rdata = w_rdata;
    assign cpu_clr_n = (r_state == RUN);
    assign ld_ready  = (r_state == LOAD);
    assign io_out    = r_io_out;
    assign io_strobe = r_io_strobe;
    assign state_o   = r_state;

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: a cycle-level reference model queues expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_mem_io_responder;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       cpu_we = 1'b0;
    logic [5:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic [7:0] cpu_rdata;
    logic       cpu_clr_n;
    logic       ld_start = 1'b0;
    logic       ld_valid = 1'b0;
    logic       ld_last = 1'b0;
    logic [7:0] ld_data = '0;
    logic       ld_ready;
    logic [7:0] io_in = '0;
    logic [7:0] io_out;
    logic       io_strobe;
    logic [1:0] state_o;

    mem_io_responder #(.AW(6), .DW(8), .IO_IN_ADDR(62), .IO_OUT_ADDR(63)) dut (
        .clk(clk), .clr(clr), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_clr_n(cpu_clr_n), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_last(ld_last), .ld_data(ld_data), .ld_ready(ld_ready), .io_in(io_in),
        .io_out(io_out), .io_strobe(io_strobe), .state_o(state_o)
    );

    always #5 clk = ~clk;

    localparam int M_HOLD = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       clrn;
        logic       rdy;
        logic [7:0] rd;
        bit         rd_known;
        logic [7:0] io;
        logic       stb;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    bit         armed = 0;

    // Reference model: bus-visible state described directly from the behavioural rules.
    int         m_mode = M_HOLD;
    int         m_ptr = 0;
    logic [7:0] m_mem [62];
    bit         m_known [62];
    logic [7:0] m_io = '0;
    bit         m_stb = 0;
    logic [7:0] m_samp[$];

    function automatic logic [7:0] model_sync();
        if (m_samp.size() >= 2) return m_samp[m_samp.size()-2];
        return 8'h00;
    endfunction

    task automatic model_edge();
        int mode0 = m_mode;
        if (clr) begin
            m_mode = M_HOLD; m_ptr = 0; m_io = '0; m_stb = 0;
            m_samp.delete();
            return;
        end
        m_stb = 0;
        if (mode0 == M_RUN && cpu_we) begin
            if (cpu_addr < 62) begin
                m_mem[cpu_addr] = cpu_wdata; m_known[cpu_addr] = 1;
            end else if (cpu_addr == 63) begin
                m_io = cpu_wdata; m_stb = 1;
            end
        end
        m_samp.push_back(io_in);
        if (m_samp.size() > 2) void'(m_samp.pop_front());
        if (mode0 == M_LOAD) begin
            if (ld_start) m_ptr = 0;
            else if (ld_valid) begin
                m_mem[m_ptr] = ld_data; m_known[m_ptr] = 1;
                m_ptr++;
                if (ld_last || m_ptr == 62) m_mode = M_RUN;
            end
        end else if (ld_start) begin
            m_mode = M_LOAD; m_ptr = 0;
        end
    endtask

    task automatic step();
        exp_t e;
        if (armed) begin
            e.cyc = cyc; e.st = 2'(m_mode); e.clrn = (m_mode == M_RUN);
            e.rdy = (m_mode == M_LOAD); e.io = m_io; e.stb = m_stb;
            e.rd = 8'h00; e.rd_known = 1;
            if (m_mode == M_RUN) begin
                if (cpu_addr == 63) e.rd = m_io;
                else if (cpu_addr == 62) e.rd = model_sync();
                else begin e.rd = m_mem[cpu_addr]; e.rd_known = m_known[cpu_addr]; end
            end
            q.push_back(e);
        end
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                chk("state_o", {6'd0, state_o}, {6'd0, e.st});
                chk("cpu_clr_n", {7'd0, cpu_clr_n}, {7'd0, e.clrn});
                chk("ld_ready", {7'd0, ld_ready}, {7'd0, e.rdy});
                chk("io_out", io_out, e.io);
                chk("io_strobe", {7'd0, io_strobe}, {7'd0, e.stb});
                if (e.rd_known) chk("cpu_rdata", cpu_rdata, e.rd);
            end
        end
    end

    task automatic quiet();
        clr = 0; cpu_we = 0; ld_start = 0; ld_valid = 0; ld_last = 0;
    endtask

    task automatic start_load();
        quiet(); ld_start = 1; step(); ld_start = 0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        quiet(); ld_valid = 1; ld_data = d; ld_last = last; step(); quiet();
    endtask

    task automatic cpu_rd(input logic [5:0] a);
        quiet(); cpu_addr = a; step();
    endtask

    task automatic cpu_wr(input logic [5:0] a, input logic [7:0] d);
        quiet(); cpu_we = 1; cpu_addr = a; cpu_wdata = d; step(); quiet();
    endtask

    initial begin : driver
        for (int i = 0; i < 62; i++) m_known[i] = 0;
        clr = 1; step(); armed = 1; step();

        // Short load ending on ld_last.
        start_load();
        send(8'hA5, 0); send(8'h3C, 0); send(8'hFF, 1);
        cpu_rd(0); cpu_rd(1); cpu_rd(2);

        // Over-long load without ld_last: only 62 bytes are taken.
        start_load();
        for (int i = 0; i < 70; i++) begin
            quiet(); ld_valid = 1; ld_data = 8'($urandom); step();
        end
        quiet();
        cpu_rd(61); cpu_rd(0);

        // Output register and strobe, including read-during-write.
        cpu_wr(63, 8'h5A);
        cpu_rd(63); cpu_rd(63);

        // Input synchroniser latency and write to the read-only input address.
        io_in = 8'h00; cpu_rd(62); cpu_rd(62);
        io_in = 8'hC3;
        for (int i = 0; i < 4; i++) cpu_rd(62);
        cpu_wr(62, 8'h77); cpu_rd(62);

        // CPU writes ignored while a reload is in progress.
        cpu_wr(10, 8'h11); cpu_rd(10);
        start_load();
        for (int i = 0; i < 3; i++) cpu_wr(10, 8'hEE);
        send(8'h01, 0); send(8'h02, 1);
        cpu_rd(10); cpu_rd(0); cpu_rd(1);

        // Reset during a load, then a fresh load.
        start_load();
        send(8'h21, 0); send(8'h22, 0);
        quiet(); clr = 1; ld_valid = 1; ld_data = 8'h99; step(); quiet();
        step(); step();
        start_load();
        send(8'h31, 0); send(8'h32, 0); send(8'h33, 1);
        cpu_rd(0); cpu_rd(1); cpu_rd(2); cpu_rd(3);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            clr       = ($urandom_range(0, 99) == 0);
            ld_start  = ($urandom_range(0, 29) == 0);
            ld_valid  = ($urandom_range(0, 1) == 0);
            ld_last   = ($urandom_range(0, 9) == 0);
            ld_data   = 8'($urandom);
            cpu_we    = ($urandom_range(0, 2) == 0);
            cpu_addr  = ($urandom_range(0, 3) == 0) ? 6'(62 + $urandom_range(0, 1)) : 6'($urandom_range(0, 63));
            cpu_wdata = 8'($urandom);
            if ($urandom_range(0, 7) == 0) io_in = 8'($urandom);
            step();
        end

        quiet(); step();
        @(negedge clk); #1;
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
